bk_kbd_ctrl: RTL and testbench

BK_KBD_CTRL -- requirements
Module: bk_kbd_ctrl

---
 rtl/bk_kbd_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bk_kbd_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_kbd_ctrl.sv
// bk_kbd_ctrl: PS/2 receiver and BK key-code decoder; define BK_KBD_FIFO_EN for 4-entry FIFO key storage.
module bk_kbd_ctrl #(
    parameter int TIMEOUT_CYC = 12500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [9:0] keymap_addr,
    input  logic [7:0] keymap_data,
    input  logic       read_kbd,
    output logic       kbd_available,
    output logic [7:0] kbd_data,
    output logic       kbd_ar2,
    output logic       stopkey,
    output logic       keydown,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    rx_state_t state, state_nx;
    logic [2:0] clk_sr;
    logic [1:0] dat_sr;
    logic fall, bit_in, timeout;
    logic [TW-1:0] tmr;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic byte_v, byte_v_nx, ferr_nx;
    logic [2:0] skip, held;
    logic ext, brk, shift, ctrl, alt, lk_v, rd_q, clr, push;
    logic [7:0] code;
    assign fall    = clk_sr[2] & ~clk_sr[1];
    assign bit_in  = dat_sr[1];
    assign timeout = state != IDLE && tmr == TW'(TIMEOUT_CYC);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            clk_sr    <= '0;
            dat_sr    <= '0;
            tmr       <= '0;
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_v    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sr    <= {clk_sr[1:0], ps2_clk};
            dat_sr    <= {dat_sr[0], ps2_dat};
            tmr       <= (fall || state == IDLE || timeout) ? '0 : tmr + 1'b1;
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            byte_v    <= byte_v_nx;
            frame_err <= ferr_nx;
        end
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        byte_v_nx  = 1'b0;
        ferr_nx    = 1'b0;
        if (timeout)
            state_nx = IDLE;
        else if (fall)
            case (state)
                IDLE: begin
                    state_nx   = bit_in ? IDLE : DATA;
                    bit_cnt_nx = '0;
                end
                DATA: begin
                    shreg_nx   = {bit_in, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    state_nx   = bit_cnt == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    state_nx = (^shreg ^ bit_in) ? STOP : IDLE;
                    ferr_nx  = ~(^shreg ^ bit_in);
                end
                default: begin
                    state_nx  = IDLE;
                    byte_v_nx = bit_in;
                    ferr_nx   = ~bit_in;
                end
            endcase
    end
    // Prefix/modifier tracking; non-modifier makes launch a one-cycle ROM lookup.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            skip        <= '0;
            held        <= '0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            shift       <= 1'b0;
            ctrl        <= 1'b0;
            alt         <= 1'b0;
            stopkey     <= 1'b0;
            lk_v        <= 1'b0;
            keymap_addr <= '0;
            rd_q        <= 1'b0;
        end else begin
            lk_v        <= 1'b0;
            keymap_addr <= '0;
            rd_q        <= read_kbd;
            if (byte_v) begin
                if (skip != 3'd0)
                    skip <= skip - 3'd1;
                else if (shreg == 8'hE1)
                    skip <= 3'd7;
                else if (shreg == 8'hE0)
                    ext <= 1'b1;
                else if (shreg == 8'hF0)
                    brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (shreg == 8'h12 || shreg == 8'h59)
                        shift <= ~brk;
                    else if (shreg == 8'h14)
                        ctrl <= ~brk;
                    else if (shreg == 8'h11)
                        alt <= ~brk;
                    else if (shreg == 8'h07)
                        stopkey <= ~brk;
                    else if (brk)
                        held <= held - 3'(held != 3'd0);
                    else begin
                        held        <= held + 3'(held != 3'd7);
                        keymap_addr <= {shift, ext, shreg};
                        lk_v        <= 1'b1;
                    end
                end
            end
        end
    assign keydown = held != 3'd0;
    assign code    = (ctrl && keymap_data[7:6] == 2'b01) ? (keymap_data & 8'h1F) : keymap_data;
    assign push    = lk_v && code != 8'h00;
    assign clr     = rd_q & ~read_kbd;
`ifdef BK_KBD_FIFO_EN
    logic [8:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt;
    logic pop, wr;
    assign pop = clr && cnt != 3'd0;
    assign wr  = push && (cnt != 3'd4 || pop);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + 2'(wr);
            rd_ptr <= rd_ptr + 2'(pop);
            cnt    <= cnt + 3'(wr) - 3'(pop);
        end
    always_ff @(posedge clk)
        if (wr)
            fifo[wr_ptr] <= {alt, code};
    assign kbd_available     = cnt != 3'd0;
    assign {kbd_ar2, kbd_data} = kbd_available ? fifo[rd_ptr] : 9'd0;
`else
    logic [8:0] hold;
    logic avail;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hold  <= '0;
            avail <= 1'b0;
        end else if (push && (!avail || clr)) begin
            hold  <= {alt, code};
            avail <= 1'b1;
        end else if (clr)
            avail <= 1'b0;
    assign kbd_available     = avail;
    assign {kbd_ar2, kbd_data} = avail ? hold : 9'd0;
`endif
endmodule

// File: tb/tb_bk_kbd_ctrl.sv
// tb_bk_kbd_ctrl: directed vector table, corner sequences and randomized byte stream against a queue model.
module tb_bk_kbd_ctrl;
    localparam int TO = 40;
    localparam int HP = 6;
`ifdef BK_KBD_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    logic clk = 0, reset_n = 0, ps2_clk = 1, ps2_dat = 1, read_kbd = 0;
    logic [9:0] keymap_addr;
    logic [7:0] keymap_data, kbd_data;
    logic kbd_available, kbd_ar2, stopkey, keydown, frame_err;
    logic [7:0] rom_tbl [1024];
    logic [9:0] last_addr = '0;
    int ferr_cnt = 0, ferr_exp = 0, checks = 0, failures = 0;

    typedef struct {
        logic [31:0] b;
        int n;
        bit bad, rd;
        logic av;
        logic [7:0] dat;
        logic ar2, stp, kd;
        logic [9:0] addr;
    } vec_t;
    vec_t vecs[$];

    logic [8:0] q[$];
    logic m_ext, m_brk, m_shift, m_ctrl, m_alt, m_stop;
    int m_skip, m_held;

    bk_kbd_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .keymap_addr(keymap_addr), .keymap_data(keymap_data), .read_kbd(read_kbd),
        .kbd_available(kbd_available), .kbd_data(kbd_data), .kbd_ar2(kbd_ar2),
        .stopkey(stopkey), .keydown(keydown), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    assign keymap_data = rom_tbl[keymap_addr];
    always @(posedge clk) begin
        if (keymap_addr != 10'd0) last_addr <= keymap_addr;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(~bad_stop);
        repeat (HP) @(negedge clk);
    endtask

    task automatic rd_pulse();
        read_kbd = 1;
        repeat (2) @(negedge clk);
        read_kbd = 0;
        repeat (3) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [31:0] b, input int n, input bit bad, input bit rd,
                                input logic av, input logic [7:0] dat, input logic ar2,
                                input logic stp, input logic kd, input logic [9:0] addr);
        vec_t v;
        v.b = b; v.n = n; v.bad = bad; v.rd = rd; v.av = av; v.dat = dat;
        v.ar2 = ar2; v.stp = stp; v.kd = kd; v.addr = addr;
        return v;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] c;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            else if (b == 8'h14) m_ctrl = !m_brk;
            else if (b == 8'h11) m_alt = !m_brk;
            else if (b == 8'h07) m_stop = !m_brk;
            else if (m_brk) m_held = m_held > 0 ? m_held - 1 : 0;
            else begin
                m_held = m_held < 7 ? m_held + 1 : 7;
                c = rom_tbl[{m_shift, m_ext, b}];
                if (m_ctrl && c >= 8'h40 && c <= 8'h7F) c = c & 8'h1F;
                if (c != 0 && q.size() < CAP) q.push_back({m_alt, c});
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    initial begin
        logic [7:0] pool [18];
        logic [7:0] five [5];
        logic [7:0] b;
        bit bad;
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h15, 8'h1D, 8'h12, 8'h59,
                 8'h14, 8'h11, 8'h07, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hE1};
        five = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        for (int i = 0; i < 1024; i++)
            rom_tbl[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        rom_tbl[10'h01C] = 8'h41; rom_tbl[10'h21C] = 8'h61; rom_tbl[10'h11C] = 8'h00;
        rom_tbl[10'h01B] = 8'h42; rom_tbl[10'h023] = 8'h43;
        rom_tbl[10'h02B] = 8'h44; rom_tbl[10'h034] = 8'h45;

        repeat (3) @(negedge clk);
        chk("rst_avail", kbd_available, 0);
        chk("rst_data", kbd_data, 0);
        chk("rst_ar2", kbd_ar2, 0);
        chk("rst_stop", stopkey, 0);
        chk("rst_keydown", keydown, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_addr", keymap_addr, 0);
        reset_n = 1;
        repeat (3) @(negedge clk);

        vecs.push_back(mk(32'h1C, 1, 0, 0, 1, 8'h41, 0, 0, 1, 10'h01C));
        vecs.push_back(mk(32'h1CF0, 2, 0, 1, 0, 8'h00, 0, 0, 0, 10'h01C));
        vecs.push_back(mk(32'h1C, 1, 1, 0, 0, 8'h00, 0, 0, 0, 10'h01C));
        vecs.push_back(mk(32'h14, 1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h01C));
        vecs.push_back(mk(32'h1C, 1, 0, 0, 1, 8'h01, 0, 0, 1, 10'h01C));
        vecs.push_back(mk(32'h1CF014F0, 4, 0, 1, 0, 8'h00, 0, 0, 0, 10'h01C));
        vecs.push_back(mk(32'h1C11, 2, 0, 0, 1, 8'h41, 1, 0, 1, 10'h01C));
        vecs.push_back(mk(32'h1CF011F0, 4, 0, 1, 0, 8'h00, 0, 0, 0, 10'h01C));
        vecs.push_back(mk(32'h07, 1, 0, 0, 0, 8'h00, 0, 1, 0, 10'h01C));
        vecs.push_back(mk(32'h07F0, 2, 0, 0, 0, 8'h00, 0, 0, 0, 10'h01C));
        vecs.push_back(mk(32'h1C12, 2, 0, 0, 1, 8'h61, 0, 0, 1, 10'h21C));
        vecs.push_back(mk(32'h1CF012F0, 4, 0, 1, 0, 8'h00, 0, 0, 0, 10'h21C));
        vecs.push_back(mk(32'h1CE0, 2, 0, 0, 0, 8'h00, 0, 0, 1, 10'h11C));
        vecs.push_back(mk(32'h1CF0E0, 3, 0, 0, 0, 8'h00, 0, 0, 0, 10'h11C));
        foreach (vecs[v]) begin
            if (vecs[v].rd) rd_pulse();
            for (int j = 0; j < vecs[v].n; j++) send(vecs[v].b[8*j +: 8], vecs[v].bad, 1'b0);
            if (vecs[v].bad) ferr_exp++;
            chk($sformatf("v%0d_ferr", v), ferr_cnt, ferr_exp);
            chk($sformatf("v%0d_avail", v), kbd_available, vecs[v].av);
            if (vecs[v].av) begin
                chk($sformatf("v%0d_data", v), kbd_data, vecs[v].dat);
                chk($sformatf("v%0d_ar2", v), kbd_ar2, vecs[v].ar2);
            end
            chk($sformatf("v%0d_stop", v), stopkey, vecs[v].stp);
            chk($sformatf("v%0d_keydown", v), keydown, vecs[v].kd);
            chk($sformatf("v%0d_addr", v), last_addr, vecs[v].addr);
        end

        // partial frame followed by silence
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        repeat (TO + 20) @(negedge clk);
        send(8'h1C, 0, 0);
        chk("to_avail", kbd_available, 1);
        chk("to_data", kbd_data, 8'h41);
        chk("to_ferr", ferr_cnt, ferr_exp);
        rd_pulse();
        send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        chk("to_keydown", keydown, 0);

        // bad stop bit
        send(8'h1C, 0, 1);
        ferr_exp++;
        chk("stop_ferr", ferr_cnt, ferr_exp);
        chk("stop_avail", kbd_available, 0);

        foreach (five[i]) send(five[i], 0, 0);
        chk("five_keydown", keydown, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("five%0d_avail", i), kbd_available, i < CAP);
            if (i < CAP) chk($sformatf("five%0d_data", i), kbd_data, 8'h41 + i);
            rd_pulse();
        end
        chk("five_empty", kbd_available, 0);
        foreach (five[i]) begin send(8'hF0, 0, 0); send(five[i], 0, 0); end
        chk("five_release", keydown, 0);

        send(8'h07, 0, 0);
        send(8'h1C, 0, 0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
        reset_n = 0;
        repeat (2) @(negedge clk);
        chk("mid_avail", kbd_available, 0);
        chk("mid_stop", stopkey, 0);
        chk("mid_keydown", keydown, 0);
        chk("mid_addr", keymap_addr, 0);
        reset_n = 1;
        repeat (2) @(negedge clk);
        send(8'h1C, 0, 0);
        chk("post_avail", kbd_available, 1);
        chk("post_data", kbd_data, 8'h41);
        chk("post_keydown", keydown, 1);
        chk("post_ferr", ferr_cnt, ferr_exp);

        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        q = {};
        {m_ext, m_brk, m_shift, m_ctrl, m_alt, m_stop} = '0;
        m_skip = 0;
        m_held = 0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                rd_pulse();
                if (q.size() > 0) void'(q.pop_front());
            end
            b = pool[$urandom_range(0, 17)];
            bad = $urandom_range(0, 11) == 0;
            send(b, bad, 1'b0);
            if (bad) ferr_exp++;
            else model_byte(b);
            chk($sformatf("r%0d_ferr", n), ferr_cnt, ferr_exp);
            chk($sformatf("r%0d_avail", n), kbd_available, q.size() != 0);
            if (q.size() != 0) begin
                chk($sformatf("r%0d_data", n), kbd_data, q[0][7:0]);
                chk($sformatf("r%0d_ar2", n), kbd_ar2, q[0][8]);
            end
            chk($sformatf("r%0d_stop", n), stopkey, m_stop);
            chk($sformatf("r%0d_keydown", n), keydown, m_held != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
